// File: rtl/i2c_reg_arbiter.sv
// Arbiter and change monitor for a shared 8-bit I2C single register: grants local writers with a
// guard interval and reports host-written values. Define I2C_REG_ARB_RR_EN for round-robin arbitration.
module i2c_reg_arbiter #(
  parameter int PORTS       = 4,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PORTS-1:0]     req_valid,
  input  logic [PORTS*8-1:0]   req_data,
  output logic [PORTS-1:0]     req_ready,
  output logic [7:0]           reg_data_in,
  output logic                 reg_data_latch,
  input  logic [7:0]           reg_data_out,
  output logic                 host_wr_valid,
  input  logic                 host_wr_ready,
  output logic [7:0]           host_wr_data,
  output logic                 host_wr_overflow,
  output logic                 busy
);

  localparam int IDXW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam logic [15:0] HOLD_INIT = 16'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LATCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  logic [15:0]      r_hold_cnt;
  logic [PORTS-1:0] r_req_ready;
  logic [7:0]       r_reg_data_in;
  logic             r_reg_data_latch;
  logic             r_busy;
  logic [7:0]       r_shadow;
  logic             r_shadow_vld;
  logic             r_host_valid;
  logic [7:0]       r_host_data;
  logic             r_host_ovf;

  logic             w_any;
  logic [IDXW-1:0]  w_grant;
  logic [IDXW-1:0]  w_idx;
  logic [7:0]       w_req_bytes [PORTS];
  logic             w_detect;

`ifdef I2C_REG_ARB_RR_EN
  logic [IDXW-1:0]  r_ptr;
  logic [IDXW-1:0]  w_ptr_next;
`endif

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      w_req_bytes[i] = req_data[i*8 +: 8];
    end
  end

  // Winner search: first asserted request, starting from the pointer in round-robin mode
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < PORTS; k++) begin
`ifdef I2C_REG_ARB_RR_EN
      w_idx = IDXW'((int'(r_ptr) + k) % PORTS);
`else
      w_idx = IDXW'(k);
`endif
      if (!w_any && req_valid[w_idx]) begin
        w_any   = 1'b1;
        w_grant = w_idx;
      end else begin
        w_grant = w_grant;
      end
    end
  end

`ifdef I2C_REG_ARB_RR_EN
  assign w_ptr_next = (w_grant == IDXW'(PORTS - 1)) ? '0 : w_grant + 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_hold_cnt       <= 16'd0;
      r_req_ready      <= '0;
      r_reg_data_in    <= 8'd0;
      r_reg_data_latch <= 1'b0;
      r_busy           <= 1'b0;
`ifdef I2C_REG_ARB_RR_EN
      r_ptr            <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_reg_data_in    <= w_req_bytes[w_grant];
            r_reg_data_latch <= 1'b1;
            r_req_ready      <= PORTS'(1'b1) << w_grant;
            r_busy           <= 1'b1;
            r_state          <= S_LATCH;
`ifdef I2C_REG_ARB_RR_EN
            r_ptr            <= w_ptr_next;
`endif
          end else begin
            r_reg_data_latch <= 1'b0;
            r_req_ready      <= '0;
            r_busy           <= 1'b0;
          end
        end
        S_LATCH: begin
          r_reg_data_latch <= 1'b0;
          r_req_ready      <= '0;
          r_hold_cnt       <= HOLD_INIT;
          if (HOLD_CYCLES == 0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_HOLD;
            r_busy  <= 1'b1;
          end
        end
        S_HOLD: begin
          if (r_hold_cnt <= 16'd1) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt - 16'd1;
          end
        end
        default: begin
          r_state          <= S_IDLE;
          r_req_ready      <= '0;
          r_reg_data_latch <= 1'b0;
          r_busy           <= 1'b0;
        end
      endcase
    end
  end

  // The latch cycle masks detection so our own write never looks like a host write
  assign w_detect = r_shadow_vld && !r_reg_data_latch && (reg_data_out != r_shadow);

  // Shadow tracking and the host-write event with sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow     <= 8'd0;
      r_shadow_vld <= 1'b0;
      r_host_valid <= 1'b0;
      r_host_data  <= 8'd0;
      r_host_ovf   <= 1'b0;
    end else begin
      if (!r_shadow_vld) begin
        r_shadow     <= reg_data_out;
        r_shadow_vld <= 1'b1;
      end else if (r_reg_data_latch) begin
        r_shadow <= r_reg_data_in;
      end else if (w_detect) begin
        r_shadow <= reg_data_out;
      end else begin
        r_shadow <= r_shadow;
      end

      if (w_detect) begin
        r_host_data  <= reg_data_out;
        r_host_valid <= 1'b1;
        if (r_host_valid && !host_wr_ready) begin
          r_host_ovf <= 1'b1;
        end else begin
          r_host_ovf <= r_host_ovf;
        end
      end else if (r_host_valid && host_wr_ready) begin
        r_host_valid <= 1'b0;
      end else begin
        r_host_valid <= r_host_valid;
      end
    end
  end

  assign req_ready        = r_req_ready;
  assign reg_data_in      = r_reg_data_in;
  assign reg_data_latch   = r_reg_data_latch;
  assign host_wr_valid    = r_host_valid;
  assign host_wr_data     = r_host_data;
  assign host_wr_overflow = r_host_ovf;
  assign busy             = r_busy;

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Scoreboard bench for i2c_reg_arbiter with a behavioural model of the shared register
// (local latch wins over a simultaneous host write).
module tb_i2c_reg_arbiter;

  localparam int PORTS = 4;
  localparam int HOLD  = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic [PORTS-1:0]   req_valid;
  logic [PORTS*8-1:0] req_data;
  logic [PORTS-1:0]   req_ready;
  logic [7:0]         reg_data_in;
  logic               reg_data_latch;
  logic [7:0]         reg_data_out;
  logic               host_wr_valid;
  logic               host_wr_ready;
  logic [7:0]         host_wr_data;
  logic               host_wr_overflow;
  logic               busy;

  logic [7:0] reg_q = 8'h00;
  logic       host_we;
  logic [7:0] host_val;

  typedef struct {
    int         port;
    logic [7:0] data;
    int         gap;
  } grant_t;

  grant_t     exp_g[$];
  logic [7:0] exp_e[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_grant = 0;

  i2c_reg_arbiter #(.PORTS(PORTS), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .reg_data_in(reg_data_in), .reg_data_latch(reg_data_latch), .reg_data_out(reg_data_out),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_wr_data(host_wr_data), .host_wr_overflow(host_wr_overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (reg_data_latch) reg_q <= reg_data_in;
    else if (host_we)   reg_q <= host_val;
  end
  assign reg_data_out = reg_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_grant(input int port, input logic [7:0] data, input int gap);
    grant_t e;
    e.port = port;
    e.data = data;
    e.gap  = gap;
    exp_g.push_back(e);
  endtask

  task automatic wait_ready(input int port, input int exp_lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[port] && n < 50);
    check("grant_latency", 32'(n), 32'(exp_lat));
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_g.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    check("grants_drained", 32'(exp_g.size()), 32'd0);
  endtask

  task automatic host_write(input logic [7:0] v);
    host_we  = 1'b1;
    host_val = v;
    step(1);
    host_we  = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_latch", 32'(reg_data_latch), 32'd0);
    check("rst_data_in", 32'(reg_data_in), 32'd0);
    check("rst_wr_valid", 32'(host_wr_valid), 32'd0);
    check("rst_wr_data", 32'(host_wr_data), 32'd0);
    check("rst_overflow", 32'(host_wr_overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
  endtask

  // Monitor: pops the scoreboard whenever a grant pulse or an accepted event appears
  always @(negedge clk) begin
    if (!rst && (req_ready != '0 || reg_data_latch)) begin
      if (exp_g.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant: got ready %0h latch %0b expected none", req_ready, reg_data_latch);
      end else begin
        grant_t e;
        e = exp_g.pop_front();
        check("grant_port", 32'(req_ready), 32'd1 << e.port);
        check("grant_data", 32'(reg_data_in), 32'(e.data));
        check("grant_latch", 32'(reg_data_latch), 32'd1);
        if (e.gap >= 0) check("grant_gap", 32'(cyc - last_grant), 32'(e.gap));
      end
      last_grant = cyc;
    end
    if (!rst && host_wr_valid && host_wr_ready) begin
      if (exp_e.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got %0h expected none", host_wr_data);
      end else begin
        logic [7:0] d;
        d = exp_e.pop_front();
        check("event_data", 32'(host_wr_data), 32'(d));
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    host_wr_ready = 1'b1;
    host_we = 1'b0;
    host_val = 8'h00;
    step(3);
    @(negedge clk);
    check_reset_outputs();
    step(1);
    rst = 1'b0;
    step(2);

    // Single request on port 2
    push_grant(2, 8'h5A, -1);
    req_data[23:16] = 8'h5A;
    req_valid = 4'b0100;
    wait_ready(2, 2);
    step(1);
    req_valid = '0;
    step(6);
    check("reg_holds_5a", 32'(reg_data_out), 32'h5A);
    check("no_event_local", 32'(host_wr_valid), 32'd0);

    // All four requesting continuously
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(2);
    for (int i = 0; i < PORTS; i++) req_data[i*8 +: 8] = 8'h10 + 8'(i);
    for (int i = 0; i < 5; i++) begin
`ifdef I2C_REG_ARB_RR_EN
      push_grant(i % PORTS, 8'h10 + 8'(i % PORTS), (i == 0) ? -1 : HOLD + 2);
`else
      push_grant(0, 8'h10, (i == 0) ? -1 : HOLD + 2);
`endif
    end
    req_valid = 4'hF;
    wait_drain(100);
    req_valid = '0;
    check("busy_in_hold", 32'(busy), 32'd1);
    step(6);
    check("busy_idle", 32'(busy), 32'd0);

    // Host write 0xC3 with delayed acceptance
    host_wr_ready = 1'b0;
    exp_e.push_back(8'hC3);
    host_write(8'hC3);
    check("event_not_early", 32'(host_wr_valid), 32'd0);
    step(1);
    check("event_valid", 32'(host_wr_valid), 32'd1);
    check("event_data_c3", 32'(host_wr_data), 32'hC3);
    step(3);
    check("event_held", 32'(host_wr_valid), 32'd1);
    host_wr_ready = 1'b1;
    step(1);
    host_wr_ready = 1'b0;
    check("event_cleared", 32'(host_wr_valid), 32'd0);
    check("no_overflow", 32'(host_wr_overflow), 32'd0);

    // Overflow: 0x11 overwritten by 0x22 while pending
    exp_e.push_back(8'h22);
    host_write(8'h11);
    step(1);
    check("ovf_first_data", 32'(host_wr_data), 32'h11);
    check("ovf_not_yet", 32'(host_wr_overflow), 32'd0);
    host_write(8'h22);
    step(1);
    check("ovf_second_data", 32'(host_wr_data), 32'h22);
    check("ovf_set", 32'(host_wr_overflow), 32'd1);
    host_wr_ready = 1'b1;
    step(1);
    host_wr_ready = 1'b0;
    step(3);
    check("ovf_valid_cleared", 32'(host_wr_valid), 32'd0);
    check("ovf_sticky", 32'(host_wr_overflow), 32'd1);

    // Reset during HOLD with a request pending on port 1
    host_wr_ready = 1'b1;
    push_grant(3, 8'h33, -1);
    req_data[31:24] = 8'h33;
    req_valid = 4'b1000;
    wait_ready(3, 2);
    step(1);
    req_valid = '0;
    step(1);
    check("hold_busy", 32'(busy), 32'd1);
    req_data[15:8] = 8'h99;
    req_valid = 4'b0010;
    step(1);
    check("req_waits_in_hold", 32'(req_ready), 32'd0);
    rst = 1'b1;
    step(1);
    check_reset_outputs();
    push_grant(1, 8'h99, -1);
    rst = 1'b0;
    wait_ready(1, 2);
    step(1);
    req_valid = '0;
    step(6);

    // Local latch of 0x7E colliding with a host write of 0x55
    push_grant(0, 8'h7E, -1);
    req_data[7:0] = 8'h7E;
    req_valid = 4'b0001;
    step(1);
    host_we = 1'b1;
    host_val = 8'h55;
    step(1);
    host_we = 1'b0;
    req_valid = '0;
    step(6);
    check("reg_holds_7e", 32'(reg_data_out), 32'h7E);
    check("no_event_collision", 32'(host_wr_valid), 32'd0);

    check("grant_queue_empty", 32'(exp_g.size()), 32'd0);
    check("event_queue_empty", 32'(exp_e.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
